// File: rtl/height_pkg.sv
// Shared types and constants for the height history block and its display neighbour.
package height_pkg;

    localparam int HIST_DEPTH = 10;

    typedef logic [7:0] inches_t;

    localparam inches_t MAX_INCHES_DEFAULT = 8'd99;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COMMIT
    } hist_state_t;

    function automatic inches_t clamp_inches(input inches_t value, input inches_t limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low push button conditioner: 2-flop synchronizer, debounce, and a
// one-cycle pulse on each accepted press (stable level 1 -> 0).
module btn_debounce #(
    parameter int DEBOUNCE_BITS = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    logic                     sync1_q, sync2_q;
    logic                     stable_q, stable_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
    logic                     press_q, press_d;

    // A differing level is accepted on its 2^DEBOUNCE_BITS-th consecutive cycle.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (&cnt_q) begin
                stable_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/height_history.sv
// Captures one clamped sensor reading per debounced save press and keeps the
// last HIST_DEPTH readings, newest in hist_0.
module height_history
    import height_pkg::*;
#(
    parameter int          DEBOUNCE_BITS = 20,
    parameter logic [23:0] ARM_TIMEOUT   = 24'd12_000_000,
    parameter inches_t     MAX_INCHES    = MAX_INCHES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       save_btn,
    input  logic       clear,
    input  logic       meas_valid,
    input  logic [7:0] meas_inches,
    output logic [7:0] hist_0,
    output logic [7:0] hist_1,
    output logic [7:0] hist_2,
    output logic [7:0] hist_3,
    output logic [7:0] hist_4,
    output logic [7:0] hist_5,
    output logic [7:0] hist_6,
    output logic [7:0] hist_7,
    output logic [7:0] hist_8,
    output logic [7:0] hist_9,
    output logic [3:0] hist_count,
    output logic       armed,
    output logic       saved,
    output logic       timeout
);

    logic        press;
    hist_state_t state_q, state_d;
    logic [23:0] tmr_q, tmr_d;
    inches_t     sample_q, sample_d;
    inches_t     hist_q [HIST_DEPTH];
    inches_t     hist_d [HIST_DEPTH];
    logic [3:0]  count_q, count_d;
    logic        saved_q, saved_d;
    logic        timeout_c;

    btn_debounce #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_btn_debounce (
        .clk   (clk),
        .reset (reset),
        .btn_n (save_btn),
        .press (press)
    );

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        sample_d  = sample_q;
        count_d   = count_q;
        saved_d   = 1'b0;
        timeout_c = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            hist_d[i] = hist_q[i];
        end

        case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = ARMED;
                    tmr_d   = '0;
                end
            end
            ARMED: begin
                tmr_d = tmr_q + 24'd1;
                // A sample arriving on the expiry cycle still wins.
                if (meas_valid) begin
                    sample_d = clamp_inches(meas_inches, MAX_INCHES);
                    state_d  = COMMIT;
                end else if (tmr_q == ARM_TIMEOUT - 24'd1) begin
                    state_d   = IDLE;
                    timeout_c = 1'b1;
                end
            end
            COMMIT: begin
                for (int i = 1; i < HIST_DEPTH; i++) begin
                    hist_d[i] = hist_q[i-1];
                end
                hist_d[0] = sample_q;
                count_d   = (count_q == 4'(HIST_DEPTH)) ? count_q : count_q + 4'd1;
                saved_d   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides any in-flight commit; the debouncer is left alone.
        if (clear) begin
            state_d   = IDLE;
            count_d   = '0;
            saved_d   = 1'b0;
            timeout_c = 1'b0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            sample_q <= '0;
            count_q  <= '0;
            saved_q  <= 1'b0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            sample_q <= sample_d;
            count_q  <= count_d;
            saved_q  <= saved_d;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign hist_0     = hist_q[0];
    assign hist_1     = hist_q[1];
    assign hist_2     = hist_q[2];
    assign hist_3     = hist_q[3];
    assign hist_4     = hist_q[4];
    assign hist_5     = hist_q[5];
    assign hist_6     = hist_q[6];
    assign hist_7     = hist_q[7];
    assign hist_8     = hist_q[8];
    assign hist_9     = hist_q[9];
    assign hist_count = count_q;
    assign armed      = (state_q == ARMED);
    assign saved      = saved_q;
    assign timeout    = timeout_c;

endmodule

// File: tb/tb_height_history.sv
// Randomized self-checking bench for height_history against a queue-based
// model of the last ten clamped saves.
module tb_height_history;

    localparam int          DB_BITS  = 4;
    localparam logic [23:0] ARM_TO   = 24'd32;
    localparam int          PRESS_LAT = 2 + (1 << DB_BITS) + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       save_btn;
    logic       clear;
    logic       meas_valid;
    logic [7:0] meas_inches;
    logic [7:0] hist_w [10];
    logic [3:0] hist_count;
    logic       armed;
    logic       saved;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q [$];

    always #5 clk = ~clk;

    height_history #(
        .DEBOUNCE_BITS(DB_BITS),
        .ARM_TIMEOUT  (ARM_TO),
        .MAX_INCHES   (8'd99)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .save_btn   (save_btn),
        .clear      (clear),
        .meas_valid (meas_valid),
        .meas_inches(meas_inches),
        .hist_0     (hist_w[0]),
        .hist_1     (hist_w[1]),
        .hist_2     (hist_w[2]),
        .hist_3     (hist_w[3]),
        .hist_4     (hist_w[4]),
        .hist_5     (hist_w[5]),
        .hist_6     (hist_w[6]),
        .hist_7     (hist_w[7]),
        .hist_8     (hist_w[8]),
        .hist_9     (hist_w[9]),
        .hist_count (hist_count),
        .armed      (armed),
        .saved      (saved),
        .timeout    (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int model_at(input int i);
        return (i < exp_q.size()) ? exp_q[i] : 0;
    endfunction

    task automatic model_commit(input int v);
        exp_q.push_front((v > 99) ? 99 : v);
        if (exp_q.size() > 10) void'(exp_q.pop_back());
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("%s_hist%0d", tag, i), 32'(hist_w[i]), 32'(model_at(i)));
        end
        chk($sformatf("%s_count", tag), 32'(hist_count), 32'(exp_q.size()));
    endtask

    // Holds the button down until armed rises; returns with armed observed (ARMED cycle 1).
    task automatic press_arm();
        int n;
        n = 0;
        save_btn = 1'b0;
        while (!armed && n < 40) begin
            tick();
            n++;
        end
        chk("press_latency", 32'(n), 32'(PRESS_LAT));
        save_btn = 1'b1;
    endtask

    task automatic do_save(input int v, input int wait_cyc);
        press_arm();
        tick(wait_cyc);
        meas_inches = 8'(v);
        meas_valid  = 1'b1;
        #1;
        chk("no_timeout_on_sample", 32'(timeout), 0);
        tick();
        meas_valid  = 1'b0;
        meas_inches = 8'($urandom);
        chk("armed_after_sample", 32'(armed), 0);
        chk("saved_too_early", 32'(saved), 0);
        tick();
        model_commit(v);
        chk("saved_pulse", 32'(saved), 1);
        check_all($sformatf("save%0d", v));
        tick();
        chk("saved_one_cycle", 32'(saved), 0);
        // A stray sample while idle must be ignored.
        tick(5);
        meas_inches = 8'($urandom);
        meas_valid  = 1'b1;
        tick();
        meas_valid  = 1'b0;
        tick(15);
        $display("save value=%0d wait=%0d count=%0d hist_0=%0d", v, wait_cyc, hist_count, hist_w[0]);
    endtask

    initial begin
        int arm_seen;
        int to_at;
        int k;

        reset       = 1'b1;
        save_btn    = 1'b1;
        clear       = 1'b0;
        meas_valid  = 1'b0;
        meas_inches = 8'd0;
        tick(2);
        check_all("reset");
        chk("reset_armed", 32'(armed), 0);
        chk("reset_saved", 32'(saved), 0);
        chk("reset_timeout", 32'(timeout), 0);
        reset = 1'b0;
        tick(3);

        do_save(42, 5);

        // Bounces shorter than the debounce window never produce a press.
        arm_seen = 0;
        for (int t = 0; t < 12; t++) begin
            save_btn = ~save_btn;
            for (int c = 0; c < 5; c++) begin
                tick();
                if (armed) arm_seen++;
            end
        end
        save_btn = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (armed) arm_seen++;
        end
        chk("bounce_no_arm", 32'(arm_seen), 0);
        $display("bounce armed_cycles=%0d", arm_seen);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
        check_all("clear_idle");

        for (int v = 1; v <= 12; v++) begin
            do_save(v, int'($urandom_range(0, 31)));
        end

        do_save(150, int'($urandom_range(0, 31)));

        // Timeout: no sample while armed.
        press_arm();
        to_at = -1;
        k = 1;
        while (armed && k <= 40) begin
            if (timeout && to_at < 0) to_at = k;
            tick();
            k++;
        end
        chk("timeout_cycle", 32'(to_at), 32'(ARM_TO));
        chk("armed_length", 32'(k - 1), 32'(ARM_TO));
        chk("timeout_one_cycle", 32'(timeout), 0);
        check_all("after_timeout");
        $display("timeout at_armed_cycle=%0d armed_len=%0d", to_at, k - 1);
        tick(20);

        // Sample on the expiry cycle wins over the timeout.
        do_save(77, 31);

        for (int r = 0; r < 6; r++) begin
            do_save(int'($urandom_range(0, 255)), int'($urandom_range(0, 31)));
        end

        // Clear in the same cycle as COMMIT.
        press_arm();
        tick(3);
        meas_inches = 8'd55;
        meas_valid  = 1'b1;
        tick();
        meas_valid  = 1'b0;
        clear       = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
        check_all("clear_commit");
        chk("clear_commit_saved", 32'(saved), 0);
        tick();
        chk("clear_commit_saved_late", 32'(saved), 0);
        chk("clear_commit_armed", 32'(armed), 0);
        $display("clear_vs_commit count=%0d saved=%0d", hist_count, saved);
        tick(20);

        do_save(int'($urandom_range(1, 99)), 3);

        // Asynchronous reset while armed.
        press_arm();
        tick(4);
        #3;
        reset = 1'b1;
        #1;
        exp_q.delete();
        check_all("async_reset");
        chk("async_reset_armed", 32'(armed), 0);
        chk("async_reset_saved", 32'(saved), 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        tick();
        meas_inches = 8'd33;
        meas_valid  = 1'b1;
        tick();
        meas_valid  = 1'b0;
        tick(3);
        check_all("post_reset");
        chk("post_reset_armed", 32'(armed), 0);
        chk("post_reset_saved", 32'(saved), 0);
        $display("reset_mid_armed count=%0d armed=%0d", hist_count, armed);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/height_history.md
Name: height_history

Overview:
- Upstream neighbour of the history display stage: captures sensor height readings on a user save request and keeps the last 10 in a shift buffer.
- Drives hist_0..hist_9 directly into the display stage; hist_0 is always the newest entry.
- Debounces the raw save button, arms on press, and commits the next valid sensor sample. Values are clamped for a 2-digit display.

Parameters:
- DEBOUNCE_BITS, 20, debounce counter width; 2^DEBOUNCE_BITS clk cycles of stable level accepts a change (~87 ms at 12 MHz)
- ARM_TIMEOUT, 24'd12_000_000, cycles to wait in ARMED for meas_valid before abandoning (1 s at 12 MHz)
- MAX_INCHES, 8'd99, clamp ceiling applied to stored values

Ports:
- clk  in  1  system clock (~12 MHz)
- reset  in  1  asynchronous, active-high reset
- save_btn  in  1  raw save button, active-low, asynchronous to clk
- clear  in  1  synchronous single-cycle clear of all history
- meas_valid  in  1  one-cycle strobe: meas_inches is a fresh reading
- meas_inches  in  8  sensor height in inches, unsigned
- hist_0 .. hist_9  out  8 each  stored heights; hist_0 newest, hist_9 oldest
- hist_count  out  4  number of valid entries, 0..10
- armed  out  1  high while waiting for a sample to commit
- saved  out  1  one-cycle pulse on the cycle after an entry is committed
- timeout  out  1  one-cycle pulse when ARMED expires with no sample

Behaviour:
- Reset, asynchronous: all hist_n = 0, hist_count = 0, armed = 0, saved = 0, timeout = 0, FSM = IDLE, debouncer stable level = 1, counters = 0.
- Button path:
  - 2-flop synchronizer, then debouncer. A level differing from the stable level must persist for 2^DEBOUNCE_BITS consecutive cycles before it is accepted.
  - Any bounce back resets the counter.
  - press = stable level 1->0 transition, a one-cycle pulse. Release is ignored.
- FSM states: IDLE, ARMED, COMMIT.
  - IDLE: on press -> ARMED. The timeout counter loads 0.
  - ARMED: armed = 1. The counter increments each cycle.
    - If meas_valid: latch clamp(meas_inches) and go to COMMIT.
    - Else if counter == ARM_TIMEOUT-1: go to IDLE and pulse timeout.
    - meas_valid wins if it arrives in the same cycle as expiry.
    - A press while ARMED is ignored and does not re-arm.
  - COMMIT: shift hist_9 <= hist_8 ... hist_1 <= hist_0, hist_0 <= latched value. hist_count <= min(hist_count+1, 10). Go to IDLE.
  - saved asserts in the cycle after the shift, so outputs are already updated when saved is seen.
- Latency: meas_valid accepted in ARMED at cycle N -> hist_0 updated at the edge ending cycle N+1 -> saved high in cycle N+2.
- Clamp: stored = (meas_inches > MAX_INCHES) ? MAX_INCHES : meas_inches. No other arithmetic.
- Full buffer: once 10 entries are held, further commits discard hist_9. hist_count holds at 10 and never wraps.
- meas_valid in IDLE or COMMIT is ignored. Only one sample is committed per press.
- clear:
  - Zeroes all hist_n and hist_count, forces FSM to IDLE, and drops armed.
  - Has priority over COMMIT in the same cycle: nothing is stored and saved does not pulse.
  - Does not affect the debouncer.
- Reset mid-operation, including during ARMED or COMMIT, returns everything immediately to reset values. No pending save survives.
- Empty entries read 0. The display shows "00" for slots at index >= hist_count.

Decomposition:
- Shared package height_pkg holds:
  - HIST_DEPTH = 10
  - typedef logic [7:0] inches_t
  - MAX_INCHES default
  - typedef enum {IDLE, ARMED, COMMIT} hist_state_t
- Internal storage is an inches_t array [HIST_DEPTH], with flat ports assigned from it.
- One sub-module, btn_debounce: synchronizer + debounce + falling-edge pulse, parameter DEBOUNCE_BITS. It is reusable by the display stage.

Test Plan:
- Bench uses DEBOUNCE_BITS = 4, ARM_TIMEOUT = 32.
- Basic save: press, hold 20 cycles, then meas_valid with 8'd42 -> hist_0 = 42, hist_count = 1, one saved pulse exactly 2 cycles after meas_valid, armed low afterwards.
- Bounce: toggle save_btn every 5 cycles for 60 cycles, then release -> armed never asserts, no press pulse.
- Fill and overflow: 12 saves of values 1..12 -> hist_0 = 12 ... hist_9 = 3, hist_count = 10 after the 10th save and after the 12th.
- Clamp and timeout: save with meas_inches = 8'd150 -> hist_0 = 99. Press with no meas_valid -> timeout pulses on cycle 32 of ARMED, history unchanged.
- Priority: clear in the same cycle as COMMIT -> all hist = 0, hist_count = 0, no saved pulse. meas_valid on the expiry cycle -> committed, no timeout.
- Reset mid-ARMED: assert reset asynchronously between clk edges -> all outputs 0 immediately. After release, a meas_valid without a new press stores nothing.
